// File: rtl/cs_pkg.sv
// Shared types and constants for the multi-beat carry-skip serial adder.
package cs_pkg;

   // Bits consumed by the adder slice on every beat.
   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cs_state_e;

   // Number of byte beats needed to add two width-bit operands.
   function automatic int unsigned calc_nbeats(input int unsigned width);
      return width / BYTE_W;
   endfunction

endpackage

// File: rtl/cs_add8.sv
// Combinational 8-bit carry-skip adder slice: two 4-bit ripple groups, with the
// upper group's carry-in forwarded straight to the carry-out when all of its
// bits propagate.
module cs_add8
   import cs_pkg::*;
(
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       CIN,
   output logic [7:0] S,
   output logic       COUT
);

   logic [7:0] p;
   logic [7:0] g;
   logic [8:0] c;
   logic       c8_ripple;
   logic       skip;

   assign p = A ^ B;
   assign g = A & B;

   // Ripple the carry through both 4-bit groups and form per-bit sums.
   always_comb begin
      c    = '0;
      c[0] = CIN;
      for (int i = 0; i < 8; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
   end

   assign S         = p ^ c[7:0];
   assign c8_ripple = c[8];
   // Skip path: upper group fully propagating passes c4 directly to the output.
   assign skip      = (&p[7:4]) & c[4];
   assign COUT      = c8_ripple | skip;

endmodule

// File: rtl/cs_serial_adder.sv
// Multi-beat wide adder: streams operands one byte per clock, LSB first,
// through an 8-bit carry-skip slice and assembles the sum in a shift register.
module cs_serial_adder
   import cs_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             COUT,
   output logic             OVF
);

   localparam int unsigned NBEATS = calc_nbeats(WIDTH);
   localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

   cs_state_e        state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             amsb_q, amsb_d;
   logic             bmsb_q, bmsb_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [7:0]       s8;
   logic             c8;
   logic [WIDTH-1:0] sum_shift;

   cs_add8 u_add8 (
      .A    (opa_q[7:0]),
      .B    (opb_q[7:0]),
      .CIN  (carry_q),
      .S    (s8),
      .COUT (c8)
   );

   // New byte enters at the top so the LSB byte ends up at the bottom after NBEATS shifts.
   if (WIDTH > BYTE_W) begin : g_wide
      assign sum_shift = {s8, sum_q[WIDTH-1:BYTE_W]};
   end else begin : g_narrow
      assign sum_shift = s8;
   end

   // Next-state logic for the controller, operand shifters and result registers.
   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      amsb_d  = amsb_q;
      bmsb_d  = bmsb_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               opa_d   = A;
               opb_d   = B;
               carry_d = CIN;
               cnt_d   = '0;
               amsb_d  = A[WIDTH-1];
               bmsb_d  = B[WIDTH-1];
               state_d = RUN;
            end
         end
         RUN: begin
            opa_d   = opa_q >> BYTE_W;
            opb_d   = opb_q >> BYTE_W;
            sum_d   = sum_shift;
            carry_d = c8;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) begin
               cout_d  = c8;
               // Carry into the MSB is a^b^s at that bit; xor with carry out gives overflow.
               ovf_d   = amsb_q ^ bmsb_q ^ s8[7] ^ c8;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         amsb_q  <= 1'b0;
         bmsb_q  <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         amsb_q  <= amsb_d;
         bmsb_q  <= bmsb_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign S         = sum_q;
   assign COUT      = cout_q;
   assign OVF       = ovf_q;

endmodule
